// File: rtl/mac4_pkg.sv
// mac4_pkg: shared constants and types for the mac4_accum block.
//   ACCUM/DONE state encoding, operand/product widths, default N/ACC_W,
//   stage-1 payload struct and a counter-width helper.
package mac4_pkg;

   localparam int unsigned OPND_W    = 4;
   localparam int unsigned PROD_W    = 8;
   localparam int unsigned N_DEF     = 8;
   localparam int unsigned ACC_W_DEF = 12;

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

   // Registered product plus its valid bit (stage 1 of the pipeline)
   typedef struct packed {
      logic              valid;
      logic [PROD_W-1:0] prod;
   } stage1_t;

   // Bits needed to count 0..n inclusive
   function automatic int unsigned cnt_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/mac4_accum_if.sv
// mac4_accum_if: operand input stream and result output stream of mac4_accum.
//   x, y, in_valid, in_ready           : 4x4 operand beats
//   out_data, out_valid, out_ready, ovf : accumulated result and overflow flag
//   master = producer/consumer side, slave = the accumulator.
interface mac4_accum_if #(
   parameter int unsigned ACC_W = mac4_pkg::ACC_W_DEF
);
   logic [mac4_pkg::OPND_W-1:0] x;
   logic [mac4_pkg::OPND_W-1:0] y;
   logic                        in_valid;
   logic                        in_ready;
   logic [ACC_W-1:0]            out_data;
   logic                        out_valid;
   logic                        out_ready;
   logic                        ovf;

   modport master (
      output x, y, in_valid, out_ready,
      input  in_ready, out_data, out_valid, ovf
   );

   modport slave (
      input  x, y, in_valid, out_ready,
      output in_ready, out_data, out_valid, ovf
   );
endinterface

// File: rtl/mul4_array.sv
// mul4_array: 4x4 unsigned array multiplier built from rows of adder cells.
//   a, b : unsigned operands
//   prod : 8-bit unsigned product (combinational)
module mul4_array
   import mac4_pkg::*;
(
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   output logic [PROD_W-1:0] prod
);

   logic [OPND_W-1:0] row;
   logic [OPND_W-1:0] part;
   logic [OPND_W-1:0] s;
   logic              c;

   // Each row adds one partial product to the running sum; bit 0 of every
   // row has no carry-in so it acts as a half adder, the rest as full adders.
   always_comb begin
      prod = '0;
      s    = '0;
      c    = 1'b0;
      row  = a & {OPND_W{b[0]}};
      prod[0] = row[0];
      part = {1'b0, row[OPND_W-1:1]};
      for (int i = 1; i < int'(OPND_W); i++) begin
         row = a & {OPND_W{b[i]}};
         c   = 1'b0;
         for (int j = 0; j < int'(OPND_W); j++) begin
            s[j] = row[j] ^ part[j] ^ c;
            c    = (row[j] & part[j]) | (c & (row[j] ^ part[j]));
         end
         prod[i] = s[0];
         part    = {c, s[OPND_W-1:1]};
      end
      prod[PROD_W-1:OPND_W] = part;
   end

endmodule

// File: rtl/mac4_accum.sv
// mac4_accum: accumulates N unsigned 4x4 products into an ACC_W-bit result.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear of the accumulation in progress
//   bus      : mac4_accum_if.slave (x/y beats in, out_data/ovf result out)
// Optional build macro MAC4_ACCUM_SAT_EN: accumulator saturates at
// 2^ACC_W-1 on overflow instead of wrapping. ovf is the same in both builds.
module mac4_accum
   import mac4_pkg::*;
#(
   parameter int unsigned N     = N_DEF,
   parameter int unsigned ACC_W = ACC_W_DEF
) (
   input logic         clk,
   input logic         rst,
   input logic         clr,
   mac4_accum_if.slave bus
);

   localparam int unsigned       CNT_W = cnt_w(N);
   localparam logic [CNT_W-1:0]  N_CNT = CNT_W'(N);
   localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

   state_t            state;
   state_t            state_nx;
   stage1_t           s1;
   logic [CNT_W-1:0]  cnt_in;
   logic [CNT_W-1:0]  cnt_add;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_nx;
   logic [ACC_W:0]    sum;
   logic              carry;
   logic [ACC_W-1:0]  out_data;
   logic              out_valid;
   logic              ovf;
   logic [PROD_W-1:0] prod_c;
   logic              ready;
   logic              accept;
   logic              last_add;
   logic              handshake;

   mul4_array u_mul (
      .a    (bus.x),
      .b    (bus.y),
      .prod (prod_c)
   );

   // Ready only while collecting beats; held low during reset so every
   // output reads zero while rst is asserted.
   assign ready     = !rst && (state == ACCUM) && (cnt_in < N_CNT) && !clr;
   assign accept    = bus.in_valid && ready;
   assign last_add  = s1.valid && (cnt_add == (N_CNT - ONE));
   assign handshake = (state == DONE) && out_valid && bus.out_ready;

   // Stage-2 adder; the extra top bit is the carry that feeds ovf
   assign sum   = {1'b0, acc} + (ACC_W+1)'(s1.prod);
   assign carry = sum[ACC_W];

`ifdef MAC4_ACCUM_SAT_EN
   assign acc_nx = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
   assign acc_nx = sum[ACC_W-1:0];
`endif

   assign bus.in_ready  = ready;
   assign bus.out_data  = out_data;
   assign bus.out_valid = out_valid;
   assign bus.ovf       = ovf;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ACCUM;
      else     state <= state_nx;
   end

   // Next-state logic; clr always returns to ACCUM
   always_comb begin
      state_nx = state;
      if (clr) begin
         state_nx = ACCUM;
      end else begin
         case (state)
            ACCUM:   if (last_add)  state_nx = DONE;
            DONE:    if (handshake) state_nx = ACCUM;
            default: state_nx = ACCUM;
         endcase
      end
   end

   // Product pipeline, accumulator, counters and result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1        <= '0;
         cnt_in    <= '0;
         cnt_add   <= '0;
         acc       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else if (clr) begin
         s1        <= '0;
         cnt_in    <= '0;
         cnt_add   <= '0;
         acc       <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         s1.valid <= accept;
         if (accept) begin
            s1.prod <= prod_c;
            cnt_in  <= cnt_in + ONE;
         end
         if (s1.valid) begin
            acc     <= acc_nx;
            cnt_add <= cnt_add + ONE;
            if (carry) ovf <= 1'b1;
            if (last_add) begin
               out_data  <= acc_nx;
               out_valid <= 1'b1;
            end
         end
         if (handshake) begin
            cnt_in    <= '0;
            cnt_add   <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
         end
      end
   end

endmodule

// File: doc/mac4_accum.md
MAC4_ACCUM -- requirements
Module: mac4_accum

Interface
REQ-001 SHALL have parameter N, default 8: products per accumulated result, 2..256.
REQ-002 SHALL have parameter ACC_W, default 12: accumulator/result width, 8..32.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port clr, input, 1: synchronous clear of the accumulation in progress.
REQ-006 SHALL have port x, input, 4: unsigned multiplicand.
REQ-007 SHALL have port y, input, 4: unsigned multiplier.
REQ-008 SHALL have port in_valid, input, 1: x/y valid.
REQ-009 SHALL have port in_ready, output, 1: block accepts x/y.
REQ-010 SHALL have port out_data, output, ACC_W: accumulated sum of N products.
REQ-011 SHALL have port out_valid, output, 1: out_data valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts out_data.
REQ-013 SHALL have port ovf, output, 1: sticky overflow flag for the current result.

Function
REQ-014 SHALL accept a beat on any rising edge where in_valid && in_ready.
REQ-015 SHALL form the 8-bit unsigned product x*y combinationally and register it, with its valid bit p_valid, on the accept edge (stage 1).
REQ-016 SHALL add the zero-extended stage-1 product into the ACC_W accumulator on the edge after acceptance (stage 2), whenever p_valid is set.
REQ-017 SHALL use a two-state FSM: ACCUM -> DONE on the edge that adds the Nth product; DONE -> ACCUM on the edge where out_valid && out_ready.
REQ-018 SHALL drive in_ready = (state==ACCUM) && (accepted count < N) && !clr, so back-to-back beats stream at 1 per cycle.
REQ-019 SHALL, on entry to DONE, register out_data = accumulator + Nth product and assert out_valid; out_valid rises 2 edges after the Nth accept edge.
REQ-020 SHALL hold out_data, out_valid and ovf stable in DONE while out_ready is low.
REQ-021 SHALL, on the out handshake edge, zero the accumulator, counters, ovf and out_valid; in_ready reasserts in the next cycle.
REQ-022 SHALL, on clr high at an edge, zero the accumulator, counters, p_valid and ovf, and return to ACCUM; clr SHALL take priority over accept and accumulate on that edge, and SHALL also clear out_valid if in DONE.
REQ-023 SHALL set ovf when any addition carries out of ACC_W bits; ovf SHALL remain set until a handshake, clr or rst.
REQ-024 SHALL ignore in_valid while in_ready is low; x/y are not sampled then.

Reset
REQ-025 SHALL, on rst, asynchronously force state=ACCUM, accumulator=0, counters=0, p_valid=0, out_data=0, out_valid=0 and ovf=0; in_ready SHALL be 1 the first cycle after rst deasserts.
REQ-026 SHALL discard any partial accumulation and pending result on rst mid-operation.

Configuration
REQ-027 SHALL, with macro MAC4_ACCUM_SAT_EN defined, clamp the accumulator to 2^ACC_W-1 on overflow, which then holds until cleared.
REQ-028 SHALL, without MAC4_ACCUM_SAT_EN, let the accumulator wrap modulo 2^ACC_W; ovf behaviour is identical in both builds.

Structure
REQ-029 SHALL place the FSM state encoding (ACCUM, DONE), the product width constant (8) and the default N/ACC_W values in a shared package, mac4_pkg.
REQ-030 SHALL implement the 4x4 unsigned product in one sub-module, mul4_array, built as a half/full-adder array; the FSM, counters and accumulator stay in mac4_accum.

Verification
REQ-031 SHALL cover this case: N=4, ACC_W=12, beats (3,5),(15,15),(0,9),(2,7) streamed back-to-back with out_ready=1 -> out_data=254, ovf=0, out_valid a single cycle 2 edges after the 4th accept.
REQ-032 SHALL cover this case: out_ready low 5 cycles after out_valid -> out_data=254 held, in_ready=0 throughout; on release, in_ready=1 the next cycle and the next result starts from 0.
REQ-033 SHALL cover this case: ACC_W=8, N=4, four beats (15,15) -> with MAC4_ACCUM_SAT_EN out_data=255 and ovf=1; without it out_data=132 and ovf=1.
REQ-034 SHALL cover this case: clr pulsed after 2 of 4 beats, then (1,1)x4 -> out_data=4, ovf=0.
REQ-035 SHALL cover this case: rst asserted mid-accumulation and while in DONE -> all outputs 0 immediately (asynchronously), in_ready=1 after release, next result uncontaminated.
REQ-036 SHALL cover this case: in_valid toggling 1-0-1 with gaps, N=8, all beats (15,15) -> out_data=1800, ovf=0.
